// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master: turns single-beat commands into one AXI-Lite write or read and returns
// exactly one response per command. A per-transaction watchdog aborts stuck transfers.
module axi_lite_master_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESETN,

  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  input  logic                    CMD_WRITE,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,

  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  output logic [1:0]              RSP_RESP,
  output logic                    RSP_TIMEOUT,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,

  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,

  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned WdogWidth =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WdogWidth-1:0] WdogMax = WdogWidth'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } state_e;

  state_e                 state_q, state_d;
  logic [WdogWidth-1:0]   wdog_q, wdog_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]   wstrb_q, wstrb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [1:0]             rsp_resp_q, rsp_resp_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic [WdogWidth-1:0]   wdog_inc;
  logic                   wdog_expire;
  logic                   aw_hs;
  logic                   w_hs;
  logic                   abort;

  // The abort fires on the edge where the saturating count reaches the limit, so the bus
  // sees exactly TIMEOUT_CYCLES busy cycles before VALID/READY are withdrawn.
  assign wdog_inc    = (wdog_q == WdogMax) ? wdog_q : wdog_q + WdogWidth'(1);
  assign wdog_expire = (TIMEOUT_CYCLES != 0) && (wdog_inc == WdogMax);
  assign aw_hs       = awvalid_q & AWREADY;
  assign w_hs        = wvalid_q & WREADY;

  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (CMD_VALID && cmd_ready_q) begin
          cmd_ready_d   = 1'b0;
          awaddr_d      = CMD_ADDR;
          araddr_d      = CMD_ADDR;
          wdata_d       = CMD_WDATA;
          wstrb_d       = CMD_WSTRB;
          wdog_d        = '0;
          rsp_timeout_d = 1'b0;
          if (CMD_WRITE) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end

      StWr: begin
        wdog_d = wdog_inc;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end else if (wdog_expire) begin
          abort = 1'b1;
        end
      end

      StWrResp: begin
        wdog_d = wdog_inc;
        if (BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (wdog_expire) begin
          abort = 1'b1;
        end
      end

      StRdAddr: begin
        wdog_d = wdog_inc;
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end else if (wdog_expire) begin
          abort = 1'b1;
        end
      end

      StRdData: begin
        wdog_d = wdog_inc;
        if (RVALID) begin
          rready_d    = 1'b0;
          rsp_data_d  = RDATA;
          rsp_resp_d  = RRESP;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (wdog_expire) begin
          abort = 1'b1;
        end
      end

      StResp: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Withdrawing VALID without READY leaves the slave in an undefined state; the bus is
    // expected to be reset after a timeout.
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_data_d    = '0;
      state_d       = StResp;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q       <= StIdle;
      wdog_q        <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign CMD_READY   = cmd_ready_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_RESP    = rsp_resp_q;
  assign RSP_TIMEOUT = rsp_timeout_q;
  assign RSP_VALID   = rsp_valid_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;

endmodule

// File: doc/axi_lite_master_ctrl.md
Name: axi_lite_master_ctrl

Overview:
- AXI4-Lite master that converts single-beat commands into AXI-Lite write or read transactions.
- Drives register-file slaves on the control bus; used by local sequencers and bring-up logic to program registers without a processor.
- Accepts one command at a time, returns exactly one response per command, and has a watchdog so a non-responding slave (e.g. an unmapped address) cannot hang the controller.

Parameters:
DATA_WIDTH, 32, AXI data width in bits; multiple of 8.
ADDR_WIDTH, 32, AXI address width in bits.
TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort; 0 disables the watchdog.

Ports:
CLK  in  1  clock
RESETN  in  1  synchronous active-low reset
CMD_ADDR  in  ADDR_WIDTH  transaction address
CMD_WDATA  in  DATA_WIDTH  write data
CMD_WSTRB  in  DATA_WIDTH/8  write byte strobes
CMD_WRITE  in  1  1=write, 0=read
CMD_VALID  in  1  command valid
CMD_READY  out  1  command accepted when VALID&&READY
RSP_DATA  out  DATA_WIDTH  read data (0 for writes and timeouts)
RSP_RESP  out  2  captured BRESP/RRESP; 2'b10 on timeout
RSP_TIMEOUT  out  1  1 = transaction aborted by watchdog
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed
AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out
ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out
- All AXI widths are ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8 or 2, as in the AXI4-Lite specification.

Behaviour:
- Reset (RESETN=0 at a CLK edge; synchronous, active-low, clock CLK):
  - All AXI VALID/READY outputs, CMD_READY, RSP_VALID and RSP_TIMEOUT are 0.
  - RSP_DATA, RSP_RESP, AWADDR, ARADDR, WDATA and WSTRB are 0.
  - FSM goes to IDLE and the watchdog counter is cleared.
  - Reset mid-transaction aborts it immediately; no response is issued.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - CMD_READY=1 (registered; it is 0 in every other state).
  - On CMD_VALID: latch all CMD_* fields and clear the watchdog.
  - CMD_WRITE=1 goes to WR; otherwise goes to RD_ADDR.
- WR:
  - AWVALID and WVALID assert in the first WR cycle, together, with the latched address, data and strobes.
  - Each VALID drops independently on the cycle after its own handshake.
  - AW-before-W, W-before-AW and simultaneous handshakes must all be handled. Per-channel done flags record completion.
  - Move to WR_RESP once both channels are done.
  - Address and data are stable while VALID is high.
- WR_RESP: BREADY=1. On BVALID: capture BRESP, set RSP_DATA=0, go to RESP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID: capture RDATA and RRESP, go to RESP.
- RESP:
  - RSP_VALID=1, with data and response held stable until RSP_READY.
  - On RSP_READY return to IDLE, so CMD_READY is 1 in the next cycle.
  - Back-to-back commands therefore have at least one IDLE cycle between them.
- Latency:
  - RSP_VALID rises the cycle after the B or R handshake.
  - Best-case command-accept to RSP_VALID is 3 cycles for both reads and writes, given zero-wait slave ready signals.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA, and saturates.
  - When it reaches TIMEOUT_CYCLES, all AXI VALID/READY outputs drop the next cycle and the FSM goes to RESP with RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_DATA=0.
  - A handshake completing in the same cycle as the timeout wins: the normal response is used and no timeout is flagged.
  - Dropping VALID without READY is a deliberate abort; the bus must be treated as needing reset afterwards.
- RSP_TIMEOUT is cleared whenever a new command is accepted.
- Any slave response code (OKAY, EXOKAY, SLVERR, DECERR) is passed through unmodified.
- Strobes are forwarded as-is; WSTRB=0 is legal.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0004, WSTRB=4'hF, slave asserts AWREADY and WREADY together -> one AW and one W handshake; RSP_VALID with RSP_RESP=0, RSP_DATA=0, RSP_TIMEOUT=0; slave register 1 = 0xDEADBEEF.
- Write to 0x8, slave delays WREADY 3 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held 3 further cycles, BREADY only after both handshakes, single response.
- Read 0x4 after the first write, slave returns RDATA=0xDEADBEEF with RRESP=0 -> RSP_DATA=0xDEADBEEF, RSP_RESP=0; response held while RSP_READY is held 0 for 5 cycles.
- Read with slave returning RRESP=2'b11 -> RSP_RESP=2'b11, RSP_TIMEOUT=0.
- TIMEOUT_CYCLES=16, write to an address the slave never acknowledges -> AWVALID and WVALID drop after 16 cycles; RSP_TIMEOUT=1, RSP_RESP=2'b10, RSP_DATA=0; next command accepted normally.
- RESETN low during RD_DATA -> all outputs return to reset values next cycle; no RSP_VALID; CMD_READY=1 the cycle after RESETN releases.
